// File: rtl/multicycle_cpu.sv
// multicycle_cpu: 16-bit ISA multi-cycle core with req/ready memory ports.
// One instruction at a time through FETCH/DECODE/EXEC/MEM/WB; r0 is general.
module multicycle_cpu #(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int DADDR_W  = 6,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset_CPU,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic               zero_flag,
    output logic               carrier_flag,
    output logic               negative_flag,
    output logic               halted,
    output logic [PC_W-1:0]    dbg_pc,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LDI  = 4'd7;
    localparam logic [3:0] OP_LD   = 4'd8;
    localparam logic [3:0] OP_ST   = 4'd9;
    localparam logic [3:0] OP_BEQZ = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [15:0]         ir;
    logic [DATA_W-1:0]   rf [8];
    logic [DATA_W-1:0]   a_q, b_q, d_q, res_q;
    logic [DADDR_W-1:0]  addr_q;
    logic                zf, cf, nf;

    logic [3:0]          op;
    logic [2:0]          rd, ra, rb;
    logic signed [5:0]   imm6;
    logic [7:0]          imm8;
    logic [DATA_W:0]     alu;
    logic [PC_W-1:0]     pc_inc, br_tgt;
    logic                upd_flags;

    assign op   = ir[15:12];
    assign rd   = ir[11:9];
    assign ra   = ir[8:6];
    assign rb   = ir[5:3];
    assign imm6 = ir[5:0];
    assign imm8 = ir[7:0];

    assign pc_inc    = pc + PC_W'(1);
    assign br_tgt    = pc_inc + PC_W'(imm6);
    assign upd_flags = (op >= OP_ADD) && (op <= OP_ADDI);

    // Bit DATA_W carries the carry-out, or the borrow for SUB.
    always_comb begin
        alu = '0;
        unique case (op)
            OP_ADD:  alu = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu = {1'b0, a_q & b_q};
            OP_OR:   alu = {1'b0, a_q | b_q};
            OP_XOR:  alu = {1'b0, a_q ^ b_q};
            OP_ADDI: alu = {1'b0, a_q} + {1'b0, DATA_W'(imm6)};
            OP_LDI:  alu = {1'b0, DATA_W'(imm8)};
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset_CPU) begin
        if (reset_CPU) begin
            state  <= S_FETCH;
            pc     <= PC_RST;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            res_q  <= '0;
            addr_q <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            nf     <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rf[ra];
                    b_q <= rf[rb];
                    d_q <= rf[rd];
                    if (op == OP_HALT) begin
                        state <= S_HALT;
                    end else if (op == OP_NOP || op > OP_JMP) begin
                        pc    <= pc_inc;
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_LD || op == OP_ST) begin
                        addr_q <= DADDR_W'(a_q + DATA_W'(imm6));
                        state  <= S_MEM;
                    end else if (op == OP_BEQZ) begin
                        pc    <= (d_q == '0) ? br_tgt : pc_inc;
                        state <= S_FETCH;
                    end else if (op == OP_JMP) begin
                        pc    <= PC_W'(imm8);
                        state <= S_FETCH;
                    end else begin
                        res_q <= alu[DATA_W-1:0];
                        if (upd_flags) begin
                            zf <= (alu[DATA_W-1:0] == '0);
                            cf <= alu[DATA_W];
                            nf <= alu[DATA_W-1];
                        end
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (op == OP_ST) begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end else begin
                            res_q <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    rf[rd] <= res_q;
                    pc     <= pc_inc;
                    state  <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign imem_req      = (state == S_FETCH) && !reset_CPU;
    assign imem_addr     = pc;
    assign dmem_req      = (state == S_MEM);
    assign dmem_we       = (state == S_MEM) && (op == OP_ST);
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = d_q;
    assign zero_flag     = zf;
    assign carrier_flag  = cf;
    assign negative_flag = nf;
    assign halted        = (state == S_HALT);
    assign dbg_pc        = pc;
    assign dbg_state     = state;

endmodule
